// File: rtl/popcount_accum_int8.sv
// Frame accumulator for per-byte popcount results: sums words and counts beats until in_last.
// Optional build macro POPCOUNT_ACCUM_SAT_EN makes the sum saturate instead of wrapping.
module popcount_accum_int8 #(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [ACC_WIDTH-1:0] out_count,
   output logic                 out_ovf
);

   // One spare bit above the wider operand so every carry out of ACC_WIDTH is visible.
   localparam int SUM_W = ((IN_WIDTH > ACC_WIDTH) ? IN_WIDTH : ACC_WIDTH) + 1;

   typedef enum logic {
      ST_ACCUM,
      ST_HOLD
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] r_cnt;
   logic                 r_ovf;
   logic [SUM_W-1:0]     w_sum;
   logic                 w_carry;
   logic [ACC_WIDTH-1:0] w_acc_nxt;
   logic [ACC_WIDTH-1:0] w_cnt_nxt;
   logic                 w_ovf_nxt;
   logic                 w_accept;

   assign w_sum   = SUM_W'(r_acc) + SUM_W'(in_data);
   assign w_carry = |w_sum[SUM_W-1:ACC_WIDTH];

`ifdef POPCOUNT_ACCUM_SAT_EN
   assign w_acc_nxt = w_carry ? '1 : w_sum[ACC_WIDTH-1:0];
`else
   assign w_acc_nxt = w_sum[ACC_WIDTH-1:0];
`endif

   assign w_cnt_nxt = r_cnt + ACC_WIDTH'(1);
   assign w_ovf_nxt = r_ovf | w_carry;
   assign w_accept  = in_valid & in_ready;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            // Held low while reset is asserted; otherwise purely a function of state.
            in_ready = rst_n;
            if (w_accept && in_last) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_ACCUM;
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_ACCUM;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            if (in_last) begin
               out_sum   <= w_acc_nxt;
               out_count <= w_cnt_nxt;
               out_ovf   <= w_ovf_nxt;
               r_acc     <= '0;
               r_cnt     <= '0;
               r_ovf     <= 1'b0;
            end else begin
               r_acc <= w_acc_nxt;
               r_cnt <= w_cnt_nxt;
               r_ovf <= w_ovf_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_popcount_accum_int8.sv
// Bench for popcount_accum_int8: a 16-bit and a 4-bit accumulator share one stimulus stream
// and are compared each cycle against a frame-level arithmetic model.
module tb_popcount_accum_int8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_last;
   logic       out_ready;
   logic [7:0] in_data;

   logic        ready16, valid16, ovf16;
   logic [15:0] sum16, cnt16;
   logic        ready4, valid4, ovf4;
   logic [3:0]  sum4, cnt4;

   typedef struct {
      int total;
      int n;
   } frame_t;

   frame_t exp_q[$];
   int     cur_total;
   int     cur_n;
   int     checks;
   int     failures;
   bit     accepted;
   int     last_sum16, last_cnt16, last_ovf16;
   int     last_sum4, last_cnt4, last_ovf4;

   always #5 clk = ~clk;

   popcount_accum_int8 #(.IN_WIDTH(8), .ACC_WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready16),
      .in_data(in_data), .in_last(in_last), .out_valid(valid16), .out_ready(out_ready),
      .out_sum(sum16), .out_count(cnt16), .out_ovf(ovf16)
   );

   popcount_accum_int8 #(.IN_WIDTH(8), .ACC_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready4),
      .in_data(in_data), .in_last(in_last), .out_valid(valid4), .out_ready(out_ready),
      .out_sum(sum4), .out_count(cnt4), .out_ovf(ovf4)
   );

   task automatic check(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Frame result as the specification defines it, from the plain sum of the words.
   function automatic int ref_sum(input int total, input int w);
`ifdef POPCOUNT_ACCUM_SAT_EN
      return (total >= (1 << w)) ? (1 << w) - 1 : total;
`else
      return total % (1 << w);
`endif
   endfunction

   // Checks at the falling edge, updates the model for the coming rising edge, then advances.
   task automatic step();
      frame_t f;
      @(negedge clk);
      accepted = 1'b0;
      check("valid16", valid16, exp_q.size() != 0);
      check("ready16", ready16, exp_q.size() == 0);
      check("valid4", valid4, exp_q.size() != 0);
      check("ready4", ready4, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
         f = exp_q[0];
         check("sum16", sum16, ref_sum(f.total, 16));
         check("count16", cnt16, f.n % 65536);
         check("ovf16", ovf16, f.total >= 65536);
         check("sum4", sum4, ref_sum(f.total, 4));
         check("count4", cnt4, f.n % 16);
         check("ovf4", ovf4, f.total >= 16);
         if (out_ready) begin
            last_sum16 = sum16; last_cnt16 = cnt16; last_ovf16 = ovf16;
            last_sum4  = sum4;  last_cnt4  = cnt4;  last_ovf4  = ovf4;
            void'(exp_q.pop_front());
         end
      end else if (in_valid) begin
         accepted  = 1'b1;
         cur_total += in_data;
         cur_n++;
         if (in_last) begin
            f.total = cur_total;
            f.n     = cur_n;
            exp_q.push_back(f);
            cur_total = 0;
            cur_n     = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input int data, input bit last, input int pv, input int pr);
      for (int t = 0; t < 64; t++) begin
         in_data   = 8'(data);
         in_last   = last;
         in_valid  = ($urandom_range(99) < pv);
         out_ready = ($urandom_range(99) < pr);
         step();
         if (accepted) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      check("beat_timeout", 0, 1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 8 && exp_q.size() != 0; t++) step();
      check("drain_empty", exp_q.size(), 0);
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst_ready16", ready16, 0);
      check("rst_valid16", valid16, 0);
      check("rst_sum16", sum16, 0);
      check("rst_count16", cnt16, 0);
      check("rst_ovf16", ovf16, 0);
      check("rst_ready4", ready4, 0);
      exp_q.delete();
      cur_total = 0;
      cur_n     = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int len;
      checks = 0; failures = 0;
      rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      do_reset();

      // Four-beat frame, immediate consume.
      send_beat(3, 0, 100, 100); send_beat(8, 0, 100, 100);
      send_beat(0, 0, 100, 100); send_beat(5, 1, 100, 100);
      drain();
      check("f4_sum", last_sum16, 16);
      check("f4_count", last_cnt16, 4);
      check("f4_ovf", last_ovf16, 0);

      // Single-beat frame held by back-pressure.
      send_beat(7, 1, 100, 0);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_sum", sum16, 7);
         check("hold_count", cnt16, 1);
      end
      drain();
      check("single_sum", last_sum16, 7);
      check("single_count", last_cnt16, 1);

      // Idle gaps inside a frame.
      send_beat(2, 0, 100, 100); step();
      send_beat(2, 0, 100, 100); step();
      send_beat(2, 1, 100, 100);
      drain();
      check("gap_sum", last_sum16, 6);
      check("gap_count", last_cnt16, 3);

      // Narrow accumulator overflow.
      send_beat(8, 0, 100, 100); send_beat(8, 0, 100, 100); send_beat(1, 1, 100, 100);
      drain();
`ifdef POPCOUNT_ACCUM_SAT_EN
      check("w4_sum", last_sum4, 15);
`else
      check("w4_sum", last_sum4, 1);
`endif
      check("w4_ovf", last_ovf4, 1);
      check("w4_count", last_cnt4, 3);
      check("w16_sum", last_sum16, 17);

      // Reset mid-frame discards the partial frame.
      send_beat(5, 0, 100, 100); send_beat(5, 0, 100, 100);
      do_reset();
      send_beat(2, 1, 100, 100);
      drain();
      check("rst_frame_sum", last_sum16, 2);
      check("rst_frame_count", last_cnt16, 1);
      check("rst_frame_ovf", last_ovf16, 0);

      // Back-to-back frames.
      send_beat(1, 0, 100, 100); send_beat(1, 1, 100, 100); send_beat(4, 1, 100, 100);
      drain();
      check("b2b_sum", last_sum16, 4);
      check("b2b_count", last_cnt16, 1);

      // Randomised frames with random gaps and back-pressure.
      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(8, 1);
         for (int b = 0; b < len; b++)
            send_beat(($urandom_range(9) == 0) ? $urandom_range(255) : $urandom_range(8),
                      b == len - 1, 70, 50);
      end
      drain();

      // Long frame that overflows the 16-bit accumulator.
      for (int b = 0; b < 260; b++) send_beat(255, b == 259, 100, 100);
      drain();
      check("long_ovf16", last_ovf16, 1);
      check("long_count16", last_cnt16, 260);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
